// File: rtl/pool_line_buffer_if.sv
// pool_line_buffer_if: raster pixel stream in, flattened pooling window out
interface pool_line_buffer_if #(
   parameter int Kh        = 3,
   parameter int Kw        = 3,
   parameter int Pin       = 2,
   parameter int BIT_WIDTH = 8
);
   logic                           in_valid;
   logic [Pin*BIT_WIDTH-1:0]       in_data;
   logic                           pool_en;
   logic [Pin*Kh*Kw*BIT_WIDTH-1:0] pool_data;
   logic                           frame_done;
   modport master (output in_valid, in_data, input pool_en, pool_data, frame_done);
   modport slave  (input in_valid, in_data, output pool_en, pool_data, frame_done);
endinterface

// File: rtl/pool_line_buffer.sv
// pool_line_buffer: line-buffered Kh x Kw strided window generator feeding the pool stage
module pool_line_buffer #(
   parameter int Kh        = 3,
   parameter int Kw        = 3,
   parameter int Pin       = 2,
   parameter int BIT_WIDTH = 8,
   parameter int IMG_W     = 16,
   parameter int IMG_H     = 16,
   parameter int STRIDE    = 2
) (
   input  logic               clk,
   input  logic               rst,
   pool_line_buffer_if.slave  bus
);
   localparam int PW  = Pin * BIT_WIDTH;
   localparam int WW  = Pin * Kh * Kw * BIT_WIDTH;
   localparam int LBN = (Kh > 1) ? Kh - 1 : 1;
   localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [CW-1:0] LAST_C = CW'(IMG_W - 1);
   localparam logic [RW-1:0] LAST_R = RW'(IMG_H - 1);

   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic [PW-1:0] r_lb  [LBN][IMG_W];
   logic [PW-1:0] r_win [Kh][Kw];
   logic          r_pool_en;
   logic          r_frame_done;
   logic [WW-1:0] r_pool_data;
   logic [PW-1:0] w_colv [Kh];
   logic [PW-1:0] w_win  [Kh][Kw];
   logic [WW-1:0] w_flat;
   logic          w_last_c;
   logic          w_last_r;
   logic          w_emit;

   assign bus.pool_en    = r_pool_en;
   assign bus.pool_data  = r_pool_data;
   assign bus.frame_done = r_frame_done;

   // current column: stored rows oldest first, the live pixel as the newest row
   always_comb begin
      for (int r = 0; r < Kh - 1; r++) w_colv[r] = r_lb[r][r_col];
      w_colv[Kh-1] = bus.in_data;
   end

   // next window: shift left by one column, new column enters at c=Kw-1
   always_comb begin
      for (int r = 0; r < Kh; r++) begin
         for (int c = 0; c < Kw - 1; c++) w_win[r][c] = r_win[r][c+1];
         w_win[r][Kw-1] = w_colv[r];
      end
   end

   // flatten channel-major so each channel's Kh x Kw block is contiguous
   always_comb begin
      w_flat = '0;
      for (int p = 0; p < Pin; p++)
         for (int r = 0; r < Kh; r++)
            for (int c = 0; c < Kw; c++)
               w_flat[((p*Kh*Kw)+r*Kw+c)*BIT_WIDTH +: BIT_WIDTH] = w_win[r][c][p*BIT_WIDTH +: BIT_WIDTH];
   end

   // emit only full windows on the stride grid; col gating keeps rows from mixing
   always_comb begin
      w_last_c = r_col == LAST_C;
      w_last_r = r_row == LAST_R;
      w_emit   = bus.in_valid && int'(r_row) >= Kh - 1 && int'(r_col) >= Kw - 1 &&
                 (int'(r_row) - (Kh - 1)) % STRIDE == 0 && (int'(r_col) - (Kw - 1)) % STRIDE == 0;
   end

   // raster position counters and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_col        <= '0;
         r_row        <= '0;
         r_pool_en    <= 1'b0;
         r_frame_done <= 1'b0;
         r_pool_data  <= '0;
      end else begin
         r_pool_en    <= w_emit;
         r_frame_done <= bus.in_valid && w_last_c && w_last_r;
         if (w_emit) r_pool_data <= w_flat;
         if (bus.in_valid) begin
            r_col <= w_last_c ? '0 : r_col + CW'(1);
            if (w_last_c) r_row <= w_last_r ? '0 : r_row + RW'(1);
         end
      end
   end

   // pixel storage is unreset: every sample is rewritten before it can be emitted
   always_ff @(posedge clk) begin
      if (bus.in_valid && !rst) begin
         for (int r = 0; r < Kh - 1; r++) r_lb[r][r_col] <= w_colv[r+1];
         for (int r = 0; r < Kh; r++)
            for (int c = 0; c < Kw; c++) r_win[r][c] <= w_win[r][c];
      end
   end
endmodule
